// File: rtl/buffer_out.sv
// Result-dump buffer: captures a frame of 64-bit words in one cycle and streams
// them out word 0 first as an AXI4-Stream master, with TLAST on the final word.
module buffer_out #(
    parameter int unsigned MEM_DEPTH  = 21,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [MEM_DEPTH*64-1:0]   din_flat,
    output logic [63:0]               m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic                      busy,
    output logic                      finish
);

    localparam int unsigned WORD_W = 64;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [WORD_W-1:0]       mem_q [MEM_DEPTH];
    logic [WORD_W-1:0]       mem_d [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic [WORD_W-1:0]       tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    busy_q, busy_d;
    logic                    finish_q, finish_d;

    assign addr_inc = rd_addr_q + ADDR_WIDTH'(1);

    // Next-state and output decode; the word after a beat is prefetched into tdata.
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        rd_addr_d = rd_addr_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        busy_d    = busy_q;
        finish_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    for (int unsigned k = 0; k < MEM_DEPTH; k++) begin
                        mem_d[k] = din_flat[WORD_W*k +: WORD_W];
                    end
                    rd_addr_d = '0;
                    tdata_d   = din_flat[WORD_W-1:0];
                    tvalid_d  = 1'b1;
                    tlast_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (m_tready) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        finish_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        rd_addr_d = addr_inc;
                        tdata_d   = mem_q[addr_inc];
                        tlast_d   = (addr_inc == LAST_ADDR);
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            for (int unsigned k = 0; k < MEM_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            rd_addr_q <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            rd_addr_q <= rd_addr_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign busy     = busy_q;
    assign finish   = finish_q;

endmodule

// File: tb/tb_buffer_out.sv
// Scoreboard bench for buffer_out: loads push the expected frame, a negedge
// monitor pops and checks every accepted beat, stall stability and finish.
module tb_buffer_out;

    localparam int unsigned DEPTH = 21;
    localparam int unsigned AW    = 5;
    localparam int unsigned FW    = DEPTH * 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [FW-1:0] din_flat;
    logic [63:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          busy;
    logic          finish;

    buffer_out #(.MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .din_flat (din_flat),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .busy     (busy),
        .finish   (finish)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       e_b;
    int          n_checks   = 0;
    int          n_fails    = 0;
    int          rdy_mode   = 0;
    int          cyc        = 0;
    int          stall_cnt  = 0;
    int          last_stall = 0;
    int          busy_cnt   = 0;
    int          fin_cnt    = 0;
    logic        stalled_p  = 1'b0;
    logic        last_beat_p = 1'b0;
    logic [63:0] data_p     = '0;
    logic        last_p     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int k = 0; k < int'(DEPTH); k++) begin
            f[64*k +: 64] = {$urandom(), $urandom()};
        end
        return f;
    endfunction

    function automatic logic [FW-1:0] incr_frame();
        logic [FW-1:0] f;
        for (int k = 0; k < int'(DEPTH); k++) begin
            f[64*k +: 64] = 64'h1000 + 64'(k);
        end
        return f;
    endfunction

    task automatic push_frame(input logic [FW-1:0] f);
        for (int k = 0; k < int'(DEPTH); k++) begin
            exp_q.push_back({f[64*k +: 64], (k == int'(DEPTH) - 1)});
        end
    endtask

    // Called just after a rising edge while the DUT is idle.
    task automatic start_frame(input logic [FW-1:0] f);
        din_flat = f;
        load     = 1'b1;
        @(posedge clk); #1;
        load     = 1'b0;
        din_flat = rand_frame();
        check("latency_valid", 64'(m_tvalid), 64'd1);
        push_frame(f);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fails++;
            $display("FAIL %s_timeout: got %0d beats outstanding expected 0", name, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_left(input int left, input int budget);
        int n = 0;
        while (exp_q.size() > left && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fails++;
            $display("FAIL wait_beats_timeout: got %0d left expected %0d", exp_q.size(), left);
        end
    endtask

    // Ready generator: always-on, 1,0,0,1 pattern, random, or stall on the last word.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2: m_tready = 1'($urandom_range(0, 1));
            default: begin
                if (m_tvalid && m_tlast && stall_cnt < 5) begin
                    m_tready = 1'b0;
                    stall_cnt++;
                end else begin
                    m_tready = 1'b1;
                end
            end
        endcase
    end

    // Monitor: a beat is valid&ready seen here, taken at the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_p   = 1'b0;
            last_beat_p = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (finish) fin_cnt++;
            check("finish", 64'(finish), 64'(last_beat_p));
            if (m_tvalid) check("busy_with_valid", 64'(busy), 64'd1);
            if (stalled_p) begin
                check("stall_valid", 64'(m_tvalid), 64'd1);
                check("stall_data", m_tdata, data_p);
                check("stall_last", 64'(m_tlast), 64'(last_p));
            end
            stalled_p   = 1'b0;
            last_beat_p = 1'b0;
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_valid: got data %0h expected no valid", m_tdata);
                end else if (m_tready) begin
                    e_b = exp_q.pop_front();
                    check("beat_data", m_tdata, e_b.data);
                    check("beat_last", 64'(m_tlast), 64'(e_b.last));
                    last_beat_p = m_tlast;
                end else begin
                    stalled_p = 1'b1;
                    data_p    = m_tdata;
                    last_p    = m_tlast;
                    if (m_tlast) last_stall++;
                end
            end
        end
    end

    initial begin
        logic [FW-1:0] f;
        int n;
        rst_n    = 1'b0;
        load     = 1'b0;
        din_flat = '0;

        #12;
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_tdata", m_tdata, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back frame with incrementing words.
        rdy_mode = 0;
        busy_cnt = 0;
        fin_cnt  = 0;
        start_frame(incr_frame());
        wait_drain("b2b", 200);
        check("busy_cycles", 64'(busy_cnt), 64'd22);
        check("finish_pulses", 64'(fin_cnt), 64'd1);

        // Backpressure 1,0,0,1 then random ready.
        rdy_mode = 1;
        start_frame(rand_frame());
        wait_drain("bp_pattern", 400);
        rdy_mode = 2;
        start_frame(rand_frame());
        wait_drain("bp_random", 400);

        // Stall on the last beat for 5 cycles.
        rdy_mode   = 3;
        stall_cnt  = 0;
        last_stall = 0;
        @(posedge clk); #1;
        start_frame(rand_frame());
        wait_drain("stall_last", 200);
        check("last_stall_cycles", 64'(last_stall), 64'd5);

        // Load mid-frame must be ignored.
        rdy_mode = 0;
        @(posedge clk); #1;
        start_frame(rand_frame());
        wait_left(int'(DEPTH) - 7, 100);
        din_flat = rand_frame();
        load     = 1'b1;
        @(posedge clk); #1;
        load     = 1'b0;
        wait_drain("ignored_load", 200);
        repeat (5) @(posedge clk);
        #1;
        check("no_second_frame", 64'(busy), 64'd0);

        // Load held across DONE: ignored in DONE, accepted in the next cycle.
        start_frame(rand_frame());
        n = 0;
        while (!finish && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("finish_seen", 64'(finish), 64'd1);
        f        = rand_frame();
        din_flat = f;
        load     = 1'b1;
        @(posedge clk); #1;
        check("done_load_ignored", 64'(m_tvalid), 64'd0);
        @(posedge clk); #1;
        load = 1'b0;
        check("load_after_finish", 64'(m_tvalid), 64'd1);
        push_frame(f);
        din_flat = rand_frame();
        wait_drain("after_finish", 200);

        // Abort at beat 10 with async reset, then restart.
        start_frame(rand_frame());
        wait_left(int'(DEPTH) - 10, 100);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_tvalid", 64'(m_tvalid), 64'd0);
        check("abort_tlast", 64'(m_tlast), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_finish", 64'(finish), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_frame(rand_frame());
        wait_drain("restart", 200);

        rdy_mode = 2;
        start_frame(rand_frame());
        wait_drain("final_random", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
